multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM plus ALU decoder for the multicycle MIPS-subset datapath.
//  Sequences each instruction through fetch/decode/execute/memory/writeback.
//  Drives the ALU function code F[2:0] and consumes the ALU zero_flag for branches.
//  Produces every mux select and write enable for the datapath.
// PARAMETERS
//  MUL_EN   1  1: R-type funct 6'h18 maps to F=3'b011 (A*B); 0: funct 6'h18 is illegal
// PORTS
//  clk          in   1  single clock; all state updates occur on the rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  op           in   6  instruction[31:26], taken from the instruction register
//  funct        in   6  instruction[5:0], taken from the instruction register
//  zero         in   1  ALU zero_flag, combinational from the current ALU result
//  alu_control  out  3  ALU F code: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 mul
//  alusrca      out  1  0: PC, 1: register A
//  alusrcb      out  2  00: B, 01: constant 4, 10: sign-extended imm, 11: sign-extended imm<<2
//  pcsrc        out  2  00: ALU result, 01: ALUOut, 10: jump target
//  iord         out  1  memory address select; 0: PC, 1: ALUOut
//  memwrite     out  1  memory write enable
//  irwrite      out  1  instruction register write enable
//  regdst       out  1  0: rt, 1: rd
//  memtoreg     out  1  0: ALUOut, 1: data register
//  regwrite     out  1  register file write enable
//  pcen         out  1  pcwrite | (branch & zero)
//  illegal_op   out  1  one-cycle pulse when an unsupported op/funct is decoded
//  state        out  4  current state encoding, for debug
// BEHAVIOUR
//  Moore FSM, 4-bit state encoding:
//   FETCH=0  DECODE=1  MEMADR=2  MEMRD=3  MEMWB=4  MEMWR=5  EXEC=6  ALUWB=7
//   BEQ=8  ADDIEX=9  ADDIWB=10  JUMP=11
//  Transitions:
//   FETCH->DECODE (always).
//   DECODE: op 6'h23/6'h2B->MEMADR; 6'h00->EXEC; 6'h04->BEQ; 6'h08->ADDIEX;
//     6'h02->JUMP; any other op->FETCH with illegal_op=1.
//   MEMADR: lw->MEMRD, sw->MEMWR.   MEMRD->MEMWB.
//   EXEC->ALUWB.   ADDIEX->ADDIWB.
//   MEMWB, MEMWR, ALUWB, BEQ, ADDIWB, JUMP -> FETCH.
//  Illegal R-type funct: EXEC->FETCH with illegal_op=1; ALUWB is skipped (no regwrite).
//  Supported funct: 20 add, 22 sub, 24 and, 25 or, 2A slt, 18 mul (MUL_EN only).
//  Per-state outputs (unlisted enables are 0; unlisted selects are don't-care, driven 0):
//   FETCH  : iord=0, alusrca=0, alusrcb=01, F=add, pcsrc=00, irwrite=1, pcwrite=1
//   DECODE : alusrca=0, alusrcb=11, F=add (computes branch target into ALUOut)
//   MEMADR : alusrca=1, alusrcb=10, F=add
//   MEMRD  : iord=1
//   MEMWR  : iord=1, memwrite=1
//   MEMWB  : regdst=0, memtoreg=1, regwrite=1
//   EXEC   : alusrca=1, alusrcb=00, F from funct
//   ALUWB  : regdst=1, memtoreg=0, regwrite=1
//   BEQ    : alusrca=1, alusrcb=00, F=sub, pcsrc=01, branch=1
//   ADDIEX : alusrca=1, alusrcb=10, F=add
//   ADDIWB : regdst=0, memtoreg=0, regwrite=1
//   JUMP   : pcsrc=10, pcwrite=1
//  pcen is combinational: in BEQ it follows the same-cycle zero.
//  Register outputs (state, illegal_op). All other outputs are combinational from state, funct and zero.
//  Reset: async assert forces state=FETCH and illegal_op=0. While rst_n=0, memwrite, irwrite,
//   regwrite and pcen are forced to 0. Reset asserted mid-instruction aborts it with no further writes.
//  Reset release is synchronous to clk; the first FETCH edge occurs on the first rising edge after deassert.
//  Instruction CPI: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3, illegal=2 (illegal R-type=3).
// TESTING
//  Reset: drop rst_n mid-MEMRD -> state=0 immediately; all write enables 0; FETCH outputs after release.
//  lw (op 23): FETCH,DECODE,MEMADR,MEMRD,MEMWB -> 5 cycles; exactly 1 regwrite pulse with memtoreg=1.
//  R-type funct 2A -> F=111 in EXEC; funct 18 -> F=011 when MUL_EN=1, illegal_op pulse when MUL_EN=0.
//  beq with zero=1 -> pcen=1, pcsrc=01 in BEQ; with zero=0 -> pcen=0; both return to FETCH.
//  Illegal op 6'h3F -> illegal_op=1 for 1 cycle in DECODE->FETCH; no memwrite or regwrite asserted.
//  Back-to-back sw, addi, j -> state trace 0,1,2,5,0,1,9,10,0,1,11,0; pcen high only in FETCH and JUMP.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM and ALU decoder for the multicycle MIPS-subset datapath.
// Moves each instruction through fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_controller #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_control,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       pcen,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BEQ    = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_MUL = 3'b011;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

  logic [3:0] next_state;
  logic [2:0] funct_alu;
  logic       funct_ok;
  logic       decode_bad;
  logic       exec_bad;
  logic       pcwrite;
  logic       branch;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regwrite_raw;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    funct_alu = F_AND;
    funct_ok  = 1'b1;
    case (funct)
      6'h20:   funct_alu = F_ADD;
      6'h22:   funct_alu = F_SUB;
      6'h24:   funct_alu = F_AND;
      6'h25:   funct_alu = F_OR;
      6'h2A:   funct_alu = F_SLT;
      6'h18: begin
        if (MUL_EN) funct_alu = F_MUL;
        else        funct_ok  = 1'b0;
      end
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    decode_bad = 1'b0;
    exec_bad   = 1'b0;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BEQ;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      decode_bad = 1'b1;
        endcase
      end
      MEMADR: next_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  next_state = MEMWB;
      EXEC: begin
        if (funct_ok) next_state = ALUWB;
        else          exec_bad   = 1'b1;
      end
      ADDIEX: next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      illegal_op <= 1'b0;
    end else begin
      state      <= next_state;
      illegal_op <= decode_bad | exec_bad;
    end
  end

  always_comb begin
    alu_control  = F_AND;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    case (state)
      FETCH: begin
        alusrcb     = 2'b01;
        alu_control = F_ADD;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
      end
      DECODE: begin
        alusrcb     = 2'b11;
        alu_control = F_ADD;
      end
      MEMADR, ADDIEX: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        alu_control = F_ADD;
      end
      MEMRD: iord = 1'b1;
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      EXEC: begin
        alusrca     = 1'b1;
        alu_control = funct_alu;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      BEQ: begin
        alusrca     = 1'b1;
        alu_control = F_SUB;
        pcsrc       = 2'b01;
        branch      = 1'b1;
      end
      ADDIWB: regwrite_raw = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: reset forces FETCH, so write enables are also gated by rst_n to keep the datapath quiet while held.
  assign memwrite = memwrite_raw & rst_n;
  assign irwrite  = irwrite_raw  & rst_n;
  assign regwrite = regwrite_raw & rst_n;
  assign pcen     = (pcwrite | (branch & zero)) & rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: two instances (MUL_EN=1 and MUL_EN=0) run directed and
// random instruction streams; expected per-cycle controls come from an instruction-level model.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] state;
    logic [2:0] f;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       pcen;
    logic       illegal_op;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic f_dc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op1 = '0, funct1 = '0, op0 = '0, funct0 = '0;
  logic       zero1 = 1'b0, zero0 = 1'b0;

  logic [2:0] alu_control1, alu_control0;
  logic       alusrca1, alusrca0;
  logic [1:0] alusrcb1, alusrcb0, pcsrc1, pcsrc0;
  logic       iord1, iord0, memwrite1, memwrite0, irwrite1, irwrite0;
  logic       regdst1, regdst0, memtoreg1, memtoreg0, regwrite1, regwrite0;
  logic       pcen1, pcen0, illegal_op1, illegal_op0;
  logic [3:0] state1, state0;

  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q0[$];
  bit   ill_pend [2];

  always #5 clk = ~clk;

  multicycle_controller #(.MUL_EN(1'b1)) dut_mul (
    .clk(clk), .rst_n(rst_n), .op(op1), .funct(funct1), .zero(zero1),
    .alu_control(alu_control1), .alusrca(alusrca1), .alusrcb(alusrcb1), .pcsrc(pcsrc1),
    .iord(iord1), .memwrite(memwrite1), .irwrite(irwrite1), .regdst(regdst1),
    .memtoreg(memtoreg1), .regwrite(regwrite1), .pcen(pcen1), .illegal_op(illegal_op1),
    .state(state1)
  );

  multicycle_controller #(.MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .op(op0), .funct(funct0), .zero(zero0),
    .alu_control(alu_control0), .alusrca(alusrca0), .alusrcb(alusrcb0), .pcsrc(pcsrc0),
    .iord(iord0), .memwrite(memwrite0), .irwrite(irwrite0), .regdst(regdst0),
    .memtoreg(memtoreg0), .regwrite(regwrite0), .pcen(pcen0), .illegal_op(illegal_op0),
    .state(state0)
  );

  ctl_t act1, act0;
  assign act1 = {state1, alu_control1, alusrca1, alusrcb1, pcsrc1, iord1, memwrite1, irwrite1,
                 regdst1, memtoreg1, regwrite1, pcen1, illegal_op1};
  assign act0 = {state0, alu_control0, alusrca0, alusrcb0, pcsrc0, iord0, memwrite0, irwrite0,
                 regdst0, memtoreg0, regwrite0, pcen0, illegal_op0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ALU code for an R-type funct; -1 marks an unsupported funct.
  function automatic int alu_of(input logic [5:0] fn, input bit mul_en);
    case (fn)
      6'h20:   return 2;
      6'h22:   return 6;
      6'h24:   return 0;
      6'h25:   return 1;
      6'h2A:   return 7;
      6'h18:   return mul_en ? 3 : -1;
      default: return -1;
    endcase
  endfunction

  // Control word the datapath should see in a given phase (phase id = debug state number).
  function automatic ctl_t phase_ctl(input int ph, input logic [5:0] fn, input bit z, input bit mul_en);
    ctl_t c;
    int   a;
    c = '0;
    c.state = 4'(ph);
    case (ph)
      0:  begin c.alusrcb = 2'b01; c.f = 3'b010; c.irwrite = 1'b1; c.pcen = 1'b1; end
      1:  begin c.alusrcb = 2'b11; c.f = 3'b010; end
      2, 9: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.f = 3'b010; end
      3:  c.iord = 1'b1;
      4:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      5:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      6:  begin
        c.alusrca = 1'b1;
        a = alu_of(fn, mul_en);
        c.f = (a < 0) ? 3'b000 : a[2:0];
      end
      7:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      8:  begin c.alusrca = 1'b1; c.f = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
      10: c.regwrite = 1'b1;
      11: begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // Issue one instruction to one instance; keep>0 truncates it to that many cycles (for aborts).
  task automatic issue(input bit which, input logic [5:0] o, input logic [5:0] fn, input bit z,
                       input int keep);
    int   seq[$];
    bit   ill;
    bit   mul_en;
    int   wait_cycles;
    exp_t e;
    mul_en = which;
    ill = 1'b0;
    case (o)
      6'h23: seq = '{0, 1, 2, 3, 4};
      6'h2B: seq = '{0, 1, 2, 5};
      6'h00: begin
        if (alu_of(fn, mul_en) >= 0) seq = '{0, 1, 6, 7};
        else begin seq = '{0, 1, 6}; ill = 1'b1; end
      end
      6'h04: seq = '{0, 1, 8};
      6'h08: seq = '{0, 1, 9, 10};
      6'h02: seq = '{0, 1, 11};
      default: begin seq = '{0, 1}; ill = 1'b1; end
    endcase
    wait_cycles = seq.size();
    if (keep > 0 && keep < seq.size()) begin
      while (seq.size() > keep) void'(seq.pop_back());
      wait_cycles = keep - 1;
    end
    if (which) begin op1 = o; funct1 = fn; zero1 = z; end
    else       begin op0 = o; funct0 = fn; zero0 = z; end
    foreach (seq[i]) begin
      e.c    = phase_ctl(seq[i], fn, z, mul_en);
      e.f_dc = (seq[i] == 6) && (alu_of(fn, mul_en) < 0);
      if (i == 0) e.c.illegal_op = ill_pend[which];
      if (which) q1.push_back(e);
      else       q0.push_back(e);
    end
    ill_pend[which] = ill;
    repeat (wait_cycles) @(posedge clk);
    #1;
  endtask

  task automatic rand_instr(input bit which);
    logic [5:0] o;
    logic [5:0] fn;
    int         k;
    k  = $urandom_range(0, 7);
    fn = 6'($urandom);
    case (k)
      0: o = 6'h23;
      1: o = 6'h2B;
      2, 3: o = 6'h00;
      4: o = 6'h04;
      5: o = 6'h08;
      6: o = 6'h02;
      default: begin
        o = 6'($urandom);
        if (o inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B}) o = 6'h3F;
      end
    endcase
    if (o == 6'h00) begin
      case ($urandom_range(0, 6))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        4: fn = 6'h2A;
        5: fn = 6'h18;
        default: ;
      endcase
    end
    issue(which, o, fn, 1'($urandom_range(0, 1)), 0);
  endtask

  // Monitor: every clock the DUTs present a control word; compare against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    ctl_t a;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = act1;
      if (e.f_dc) a.f = e.c.f;
      check($sformatf("dut_mul ctl state %0d", e.c.state), 32'(a), 32'(e.c));
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = act0;
      if (e.f_dc) a.f = e.c.f;
      check($sformatf("dut_nomul ctl state %0d", e.c.state), 32'(a), 32'(e.c));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ill_pend[0] = 1'b0;
    ill_pend[1] = 1'b0;
    @(negedge clk);
    check("reset state", 32'(state1), 32'd0);
    check("reset enables", 32'({memwrite1, irwrite1, regwrite1, pcen1}), 32'd0);
    check("reset illegal_op", 32'(illegal_op1), 32'd0);
    check("reset state nomul", 32'(state0), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back sw, addi, j: trace 0,1,2,5,0,1,9,10,0,1,11
    issue(1'b1, 6'h2B, 6'h11, 1'b0, 0);
    issue(1'b1, 6'h08, 6'h05, 1'b1, 0);
    issue(1'b1, 6'h02, 6'h00, 1'b0, 0);
    issue(1'b1, 6'h23, 6'h20, 1'b0, 0);
    issue(1'b1, 6'h00, 6'h2A, 1'b0, 0);
    issue(1'b1, 6'h00, 6'h18, 1'b0, 0);
    issue(1'b1, 6'h04, 6'h00, 1'b1, 0);
    issue(1'b1, 6'h04, 6'h00, 1'b0, 0);
    issue(1'b1, 6'h3F, 6'h20, 1'b0, 0);
    issue(1'b1, 6'h00, 6'h3B, 1'b1, 0);
    issue(1'b1, 6'h00, 6'h20, 1'b0, 0);

    // lw aborted by reset while in MEMRD
    issue(1'b1, 6'h23, 6'h00, 1'b0, 4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    ill_pend[0] = 1'b0;
    ill_pend[1] = 1'b0;
    #1;
    check("abort state", 32'(state1), 32'd0);
    check("abort enables", 32'({memwrite1, irwrite1, regwrite1, pcen1}), 32'd0);
    @(posedge clk);
    #1;
    check("held reset state", 32'(state1), 32'd0);
    check("held reset enables", 32'({memwrite1, irwrite1, regwrite1, pcen1}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    fork
      begin
        issue(1'b0, 6'h00, 6'h18, 1'b0, 0);
        issue(1'b0, 6'h00, 6'h2A, 1'b0, 0);
        for (int i = 0; i < 40; i++) rand_instr(1'b0);
        issue(1'b0, 6'h02, 6'h00, 1'b0, 0);
      end
      begin
        issue(1'b1, 6'h23, 6'h00, 1'b0, 0);
        for (int i = 0; i < 40; i++) rand_instr(1'b1);
        issue(1'b1, 6'h02, 6'h00, 1'b0, 0);
      end
    join

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(q1.size() + q0.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
